// File: rtl/dac_stage_pkg.sv
// dac_stage_pkg: shared widths, DAC constants and window FSM states for the DAC output stage.
package dac_stage_pkg;
    localparam int DEF_DSP_W = 13;
    localparam int DEF_DAC_W = 14;
    localparam int DEF_CNT_W = 8;
    localparam logic [13:0] DAC_MIDSCALE = 14'h2000;
    localparam int SAT_MAX = 8191;
    localparam int SAT_MIN = -8192;
    typedef enum logic [1:0] {IDLE, DELAY, ACTIVE} state_t;
endpackage

// File: rtl/dac_sat_add.sv
// dac_sat_add: signed sample plus offset, clamped to the DAC range with a saturation flag.
module dac_sat_add import dac_stage_pkg::*; #(
    parameter int DSP_W = DEF_DSP_W,
    parameter int DAC_W = DEF_DAC_W
) (
    input  logic signed [DSP_W-1:0] sample,
    input  logic signed [DAC_W-1:0] offset,
    output logic signed [DAC_W-1:0] result,
    output logic                    sat
);
    localparam logic signed [DAC_W:0] HI = (DAC_W+1)'(SAT_MAX);
    localparam logic signed [DAC_W:0] LO = (DAC_W+1)'(SAT_MIN);
    logic signed [DAC_W:0] sum;
    always_comb begin
        sum = (DAC_W+1)'(sample) + (DAC_W+1)'(offset);
        sat = sum > HI || sum < LO;
        result = sum > HI ? HI[DAC_W-1:0] : sum < LO ? LO[DAC_W-1:0] : sum[DAC_W-1:0];
    end
endmodule

// File: rtl/dac_output_stage.sv
// dac_output_stage: strobe-windowed offset/saturate/invert of DSP samples into an offset-binary DAC word,
// with a per-window saturation event counter.
module dac_output_stage import dac_stage_pkg::*; #(
    parameter int DSP_W = DEF_DSP_W,
    parameter int DAC_W = DEF_DAC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [DSP_W-1:0] dsp_in,
    input  logic                    bunch_strb,
    input  logic        [CNT_W-1:0] start_dly,
    input  logic        [CNT_W-1:0] gate_len,
    input  logic signed [DAC_W-1:0] dac_offset,
    input  logic                    polarity,
    output logic        [DAC_W-1:0] dac_out,
    output logic                    gate_active,
    output logic        [CNT_W-1:0] sat_count
);
    localparam logic signed [DAC_W-1:0] VMAX = DAC_W'(SAT_MAX);
    localparam logic signed [DAC_W-1:0] VMIN = DAC_W'(SAT_MIN);
    state_t state, state_nxt;
    logic prev, strb_edge, in_win, gated, pol_s, pol_e, pol1, g1, sat;
    logic [CNT_W-1:0] sd_s, gl_s, sd_e, gl_e;
    logic signed [DAC_W-1:0] off_s, off_e, off1, clamped, val;
    logic signed [DSP_W-1:0] d1;
    logic [CNT_W:0] n_cnt, n_cur, n_nxt, win_beg, win_end;

    dac_sat_add #(.DSP_W(DSP_W), .DAC_W(DAC_W)) u_sat (
        .sample(d1),
        .offset(off1),
        .result(clamped),
        .sat(sat)
    );

    // The edge-cycle sample already belongs to the new window, so it sees the live config.
    always_comb begin
        strb_edge = bunch_strb && !prev;
        sd_e = strb_edge ? start_dly : sd_s;
        gl_e = strb_edge ? gate_len : gl_s;
        off_e = strb_edge ? dac_offset : off_s;
        pol_e = strb_edge ? polarity : pol_s;
        n_cur = strb_edge ? '0 : n_cnt;
        n_nxt = n_cur + (CNT_W+1)'(1);
        win_beg = {1'b0, sd_e};
        win_end = win_beg + {1'b0, gl_e};
        in_win = strb_edge || state != IDLE;
        gated = in_win && n_cur >= win_beg && n_cur < win_end;
        state_nxt = !in_win || gl_e == '0 || n_nxt >= win_end ? IDLE : n_nxt >= win_beg ? ACTIVE : DELAY;
        val = !pol1 ? clamped : clamped == VMIN ? VMAX : -clamped;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b1;
            state <= IDLE;
            n_cnt <= '0;
            sd_s <= '0;
            gl_s <= '0;
            off_s <= '0;
            pol_s <= 1'b0;
            d1 <= '0;
            off1 <= '0;
            pol1 <= 1'b0;
            g1 <= 1'b0;
            dac_out <= DAC_MIDSCALE;
            gate_active <= 1'b0;
            sat_count <= '0;
        end else begin
            prev <= bunch_strb;
            state <= state_nxt;
            n_cnt <= n_nxt;
            sd_s <= sd_e;
            gl_s <= gl_e;
            off_s <= off_e;
            pol_s <= pol_e;
            d1 <= dsp_in;
            off1 <= off_e;
            pol1 <= pol_e;
            g1 <= gated;
            dac_out <= g1 ? val ^ DAC_MIDSCALE : DAC_MIDSCALE;
            gate_active <= g1;
            sat_count <= strb_edge ? '0 : g1 && sat && sat_count != '1 ? sat_count + CNT_W'(1) : sat_count;
        end
    end
endmodule

// File: tb/tb_dac_output_stage.sv
// tb_dac_output_stage: directed windows with hand-computed expected words, checked by a cycle-tagged scoreboard.
module tb_dac_output_stage;
    localparam logic [13:0] MID = 14'h2000;
    typedef struct {
        int c;
        logic [13:0] d;
        logic g;
        logic [7:0] s;
        logic k;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [12:0] dsp_in = '0;
    logic bunch_strb = 1'b1;
    logic [7:0] start_dly = 8'd0;
    logic [7:0] gate_len = 8'd5;
    logic signed [13:0] dac_offset = '0;
    logic polarity = 1'b0;
    logic [13:0] dac_out;
    logic gate_active;
    logic [7:0] sat_count;

    exp_t q[$];
    exp_t e;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    dac_output_stage dut (
        .clk(clk),
        .rst(rst),
        .dsp_in(dsp_in),
        .bunch_strb(bunch_strb),
        .start_dly(start_dly),
        .gate_len(gate_len),
        .dac_offset(dac_offset),
        .polarity(polarity),
        .dac_out(dac_out),
        .gate_active(gate_active),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_check cyc=%0d got=none want=%0d", cyc, q[0].c);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].c == cyc) begin
            e = q.pop_front();
            chk("dac_out", int'(dac_out), int'(e.d));
            chk("gate_active", int'(gate_active), int'(e.g));
            if (e.k) chk("sat_count", int'(sat_count), int'(e.s));
        end
    end

    task automatic push(input int c, input logic [13:0] d, input logic g, input logic [7:0] s, input logic k);
        q.push_back('{c, d, g, s, k});
    endtask

    // Drives one cycle of inputs and records what that sample must produce two cycles later.
    task automatic tick(input logic r, input logic s, input int d, input logic [13:0] xd, input logic xg,
                        input logic [7:0] xs, input logic xk);
        @(posedge clk);
        #1;
        rst = r;
        bunch_strb = s;
        dsp_in = 13'(d);
        push(cyc + 2, xd, xg, xs, xk);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, MID, 0, 0, 0);
    endtask

    task automatic cfg(input int sd, input int gl, input int off, input logic pol);
        start_dly = 8'(sd);
        gate_len = 8'(gl);
        dac_offset = 14'(off);
        polarity = pol;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            dsp_in = 13'($urandom);
            push(cyc, MID, 0, 0, 1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(cyc, MID, 0, 0, 1);
        push(cyc + 1, MID, 0, 0, 1);
        // strobe held high through reset must not open a window
        for (int i = 0; i < 3; i++) tick(0, 1, 100, MID, 0, 0, 1);
        gap(3);

        cfg(4, 3, 0, 0);
        for (int n = 0; n < 10; n++) begin
            logic g;
            g = n >= 4 && n < 7;
            tick(0, n == 0, 100, g ? 14'h2064 : MID, g, 0, 1);
        end
        gap(2);

        cfg(1, 4, 8000, 0);
        for (int n = 0; n < 8; n++) begin
            logic g;
            g = n >= 1 && n < 5;
            tick(0, n == 0, 4000, g ? 14'h3FFF : MID, g, 8'(n > 4 ? 4 : n), 1);
        end
        gap(2);

        cfg(0, 2, -8000, 1);
        for (int n = 0; n < 6; n++) begin
            logic g;
            g = n < 2;
            tick(0, n == 0, -4096, g ? 14'h3FFF : MID, g, 8'(n == 0 ? 1 : 2), 1);
        end
        gap(2);

        cfg(2, 0, 0, 0);
        for (int n = 0; n < 7; n++) tick(0, n == 0, 100, MID, 0, 0, 1);
        gap(2);

        cfg(3, 2, -50, 1);
        for (int n = 0; n < 7; n++) begin
            logic g;
            g = n >= 3 && n < 5;
            tick(0, n == 0, 100, g ? 14'h1FCE : MID, g, 0, 1);
        end
        gap(2);

        cfg(2, 10, 8000, 0);
        for (int n = 0; n < 20; n++) begin
            logic g;
            int s;
            g = (n >= 2 && n < 5) || (n >= 7 && n < 17);
            s = n < 2 ? 0 : n < 4 ? n - 1 : n < 7 ? 0 : n < 17 ? n - 6 : 10;
            tick(0, n == 0 || n == 5, 4000, g ? 14'h3FFF : MID, g, 8'(s), 1);
            if (n == 8) cfg(0, 1, 0, 1);
        end
        gap(2);

        cfg(0, 10, 0, 0);
        for (int n = 0; n < 15; n++) begin
            logic g;
            g = n < 3;
            tick(n == 4, n == 0, 100, g ? 14'h2064 : MID, g, 0, 1);
        end
        gap(2);

        cfg(0, 1, -8000, 1);
        for (int n = 0; n < 5; n++) tick(0, n == 0, -192, n == 0 ? 14'h3FFF : MID, n == 0, 0, 1);
        gap(2);

        repeat (4) @(posedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
